// File: rtl/writeback_unit.sv
// Writeback stage: buffers execute results in an in-order FIFO and retires each one
// to the register file over a four-phase storeNow/storeDone handshake.
module writeback_unit #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exValid,
  output logic        exReady,
  input  logic [3:0]  exDestReg,
  input  logic [15:0] exResult,
  output logic [3:0]  destReg,
  output logic [15:0] destVal,
  output logic        storeNow,
  input  logic        storeDone,
  output logic [15:0] pending,
  output logic        busy,
  output logic        timeoutErr,
  output logic [15:0] retireCount,
  output logic [1:0]  dbgState
);

  // Handshake: exValid/exReady push on a posedge where both are high; exReady depends only
  // on registered occupancy. storeNow rises, stays high until storeDone is sampled, then
  // falls; the next request waits until storeDone has returned low.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [7:0] TMAX = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t state, nextState;

  logic [3:0]    memReg [DEPTH];
  logic [15:0]   memVal [DEPTH];
  logic [PW-1:0] wrPtr, rdPtr, idx;
  logic [CW-1:0] count;
  logic [7:0]    timer;
  logic          push, pop, fifoEmpty, loadHead;

  assign fifoEmpty = (count == '0);
  assign exReady   = (count < CW'(DEPTH));
  assign push      = exValid & exReady;
  // The head stays in the FIFO while its store is in flight and is popped on acknowledge.
  assign pop       = (state == REQ) & storeDone;
  assign loadHead  = (state == IDLE) & ~fifoEmpty;

  always_ff @(posedge clk) begin
    if (push) begin
      memReg[wrPtr] <= exDestReg;
      memVal[wrPtr] <= exResult;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + PW'(1);
      if (pop)  rdPtr <= rdPtr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (!fifoEmpty) nextState = REQ;
      REQ:     if (storeDone)  nextState = RELEASE;
      RELEASE: if (!storeDone) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    storeNow = (state == REQ);
    busy     = ~fifoEmpty | (state != IDLE);
    dbgState = state;
    pending  = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rdPtr + PW'(i);
      if (CW'(i) < count) pending[memReg[idx]] = 1'b1;
    end
    if (state != IDLE) pending[destReg] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      destReg     <= '0;
      destVal     <= '0;
      timer       <= '0;
      timeoutErr  <= 1'b0;
      retireCount <= '0;
    end else begin
      if (loadHead) begin
        destReg <= memReg[rdPtr];
        destVal <= memVal[rdPtr];
        timer   <= '0;
      end else if (state == REQ && timer != TMAX) begin
        timer <= timer + 8'd1;
      end
      // Flag on the cycle the timer would reach the limit without an acknowledge.
      if (state == REQ && !storeDone && timer == TMAX - 8'd1) timeoutErr <= 1'b1;
      if (pop) retireCount <= retireCount + 16'd1;
    end
  end

endmodule
